// File: rtl/cover_pkg.sv
// Shared widths and arithmetic helpers for the toggle cover scheduler.
package cover_pkg;

    localparam int IDX_W_DEF = 64;
    localparam int CNT_W_DEF = 16;

    // Reported index = base + bit offset, unsigned, wraps silently.
    function automatic logic [63:0] index_add(input logic [63:0] base, input logic [63:0] off);
        return base + off;
    endfunction

    // Counter increment that sticks at max instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max);
        return (value >= max) ? max : value + 64'd1;
    endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit finder: reports whether any bit is set, its binary position and a one-hot mask.
module cover_prio_enc #(
    parameter int WIDTH = 65,
    parameter int BIN_W = 7
) (
    input  logic [WIDTH-1:0] vec,
    output logic             found,
    output logic [BIN_W-1:0] bin,
    output logic [WIDTH-1:0] onehot
);

    assign found  = |vec;
    // Two's-complement trick isolates the lowest set bit.
    assign onehot = vec & (~vec + WIDTH'(1));

    // Each binary index bit is the OR of the one-hot bits whose position has that bit set.
    for (genvar gi = 0; gi < BIN_W; gi++) begin : g_bin
        logic [WIDTH-1:0] plane;

        // Constant mask of positions with bit gi set.
        always_comb begin
            plane = '0;
            for (int i = 0; i < WIDTH; i++) begin
                plane[i] = ((i >> gi) & 1) != 0;
            end
        end

        assign bin[gi] = |(onehot & plane);
    end

endmodule

// File: rtl/toggle_cover_scheduler.sv
// Sticky per-bit toggle cover collector that serialises newly hit points onto one valid/ready channel.
module toggle_cover_scheduler
    import cover_pkg::*;
#(
    parameter int          WIDTH       = 65,
    parameter logic [63:0] COVER_INDEX = 64'd0,
    parameter int          IDX_W       = IDX_W_DEF,
    parameter int          CNT_W       = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [CNT_W-1:0] hit_count,
    output logic             all_covered
);

    localparam int          BIN_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [63:0] CNT_MAX = (CNT_W >= 64) ? '1 : ((64'd1 << CNT_W) - 64'd1);

    logic [WIDTH-1:0] seen_reg, seen_next;
    logic [WIDTH-1:0] pending_reg, pending_next;
    logic [WIDTH-1:0] slot_onehot_reg;
    logic             slot_counts_reg, slot_counts_next;
    logic             out_valid_reg;
    logic [IDX_W-1:0] out_index_reg;
    logic [CNT_W-1:0] hit_count_reg, hit_count_next;
    logic             all_covered_reg;

    logic [WIDTH-1:0] seen_base, pending_base, new_hits, slot_mask, candidates;
    logic             handshake, load;
    logic             sel_found;
    logic [BIN_W-1:0] sel_bin;
    logic [WIDTH-1:0] sel_onehot;

    cover_prio_enc #(
        .WIDTH (WIDTH),
        .BIN_W (BIN_W)
    ) u_prio (
        .vec    (candidates),
        .found  (sel_found),
        .bin    (sel_bin),
        .onehot (sel_onehot)
    );

    // Clear wipes history first, then this cycle's hits are applied on top of the clean state.
    always_comb begin
        seen_base    = clear ? '0 : seen_reg;
        pending_base = clear ? '0 : pending_reg;
        new_hits     = enable ? (valid & ~seen_base) : '0;
        // A point re-hit after clear while still sitting in the slot waits until the slot moves on.
        slot_mask    = out_valid_reg ? slot_onehot_reg : '0;
        candidates   = (pending_base | new_hits) & ~slot_mask;
        handshake    = out_valid_reg & out_ready;
        load         = (~out_valid_reg | handshake) & sel_found;
        seen_next    = seen_base | new_hits;
        pending_next = (pending_base | new_hits) & ~(load ? sel_onehot : '0);

        // A slot loaded before a clear still drains but no longer counts.
        slot_counts_next = slot_counts_reg;
        if (load) begin
            slot_counts_next = 1'b1;
        end else if (clear) begin
            slot_counts_next = 1'b0;
        end

        hit_count_next = hit_count_reg;
        if (clear) begin
            hit_count_next = '0;
        end else if (handshake && slot_counts_reg) begin
            hit_count_next = CNT_W'(sat_inc(64'(hit_count_reg), CNT_MAX));
        end
    end

    // State vectors, report slot, counter and coverage flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            seen_reg        <= '0;
            pending_reg     <= '0;
            slot_onehot_reg <= '0;
            slot_counts_reg <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_index_reg   <= '0;
            hit_count_reg   <= '0;
            all_covered_reg <= 1'b0;
        end else begin
            seen_reg        <= seen_next;
            pending_reg     <= pending_next;
            slot_counts_reg <= slot_counts_next;
            hit_count_reg   <= hit_count_next;
            all_covered_reg <= &seen_next;
            if (load) begin
                out_valid_reg   <= 1'b1;
                out_index_reg   <= IDX_W'(index_add(COVER_INDEX, 64'(sel_bin)));
                slot_onehot_reg <= sel_onehot;
            end else if (handshake) begin
                out_valid_reg   <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_index   = out_index_reg;
    assign hit_count   = hit_count_reg;
    assign all_covered = all_covered_reg;

endmodule
